// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Default number of memory access cycles (legal range 1..15).
    localparam int DEFAULT_LATENCY = 4;

    // Width of the access cycle counter; wide enough for LATENCY-1 = 14.
    localparam int CNT_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Which requester owns the current access.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    // A lone requester always wins. On a conflict the port that did not
    // get the previous grant wins, so neither side can be starved.
    function automatic grant_e pick_winner(input logic   if_req,
                                           input logic   dm_req,
                                           input grant_e last_grant);
        grant_e win;
        if (if_req && dm_req) begin
            win = (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (dm_req) begin
            win = GNT_DM;
        end else begin
            win = GNT_IF;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch port and
// the data port. A grant latches the winning request; the memory is driven
// for LATENCY cycles and the winner then sees a one-cycle ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    // data port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter value seen in the final BUSY cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    arb_state_e        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    grant_e            gnt_q,      gnt_d;
    grant_e            last_q,     last_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    // State, counter, request latches and read-data holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= GNT_IF;
            last_q     <= GNT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Next-state logic: arbitrate and latch in IDLE, count through BUSY,
    // capture read data in the last BUSY cycle, then one DONE cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    gnt_d  = pick_winner(if_req, dm_req, last_q);
                    last_d = gnt_d;
                    cnt_d  = '0;
                    if (gnt_d == GNT_DM) begin
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                    end else begin
                        // Fetch never writes; keep the write-data latch quiet.
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Writes leave both read-data registers untouched.
                    if (!we_q) begin
                        if (gnt_q == GNT_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only from state and latches; no request-to-memory path.
    assign mem_en    = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = (state_q == DONE) && (gnt_q == GNT_IF);
    assign dm_ready  = (state_q == DONE) && (gnt_q == GNT_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences, a table of single
// accesses, and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Power-up memory contents; 0x10 holds the fetch test pattern.
    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 16'hA5A5;
        return {a, ~a} ^ 16'h3C69;
    endfunction

    // Backing memory: 256 words aliased on addr[7:0]. Read data is only
    // correct in the last BUSY cycle and inverted otherwise.
    logic [15:0] mem_arr [256];
    bit          wr_valid [256];
    logic [3:0]  en_cnt = '0;
    logic [15:0] mem_word;

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:0]]  <= mem_wdata;
            wr_valid[mem_addr[7:0]] <= 1'b1;
        end
        en_cnt <= mem_en ? en_cnt + 4'd1 : 4'd0;
    end

    assign mem_word  = wr_valid[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    assign mem_rdata = (mem_en && en_cnt == 4'(L - 1)) ? mem_word : ~mem_word;

    // Reference contents and expected read-data registers.
    logic [15:0] ref_mem [256];
    logic [15:0] exp_if_rd = '0;
    logic [15:0] exp_dm_rd = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1 ("rst.mem_en",    mem_en,    1'b0);
        chk1 ("rst.mem_we",    mem_we,    1'b0);
        chk16("rst.mem_addr",  mem_addr,  16'h0);
        chk16("rst.mem_wdata", mem_wdata, 16'h0);
        chk1 ("rst.if_ready",  if_ready,  1'b0);
        chk1 ("rst.dm_ready",  dm_ready,  1'b0);
        chk16("rst.if_rdata",  if_rdata,  16'h0);
        chk16("rst.dm_rdata",  dm_rdata,  16'h0);
        exp_if_rd = '0;
        exp_dm_rd = '0;
        rst_n = 1'b1;
    endtask

    // Called at the falling edge of the IDLE cycle with the request already
    // driven; walks BUSY and DONE. With scramble set, every request input
    // (including both reqs) is disturbed during BUSY and restored at DONE.
    task automatic do_access(input string tag, input bit win_if, input logic [15:0] addr,
                             input bit we, input logic [15:0] wdata, input bit scramble);
        logic [15:0] s_if_addr, s_dm_addr, s_wdata, exp_rd;
        logic        s_we, s_if_req, s_dm_req;
        exp_rd = ref_mem[addr[7:0]];
        if (we) ref_mem[addr[7:0]] = wdata;
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            chk1($sformatf("%s.mem_en c%0d", tag, c), mem_en, c <= L);
            chk1($sformatf("%s.if_ready c%0d", tag, c), if_ready, (c == L + 1) && win_if);
            chk1($sformatf("%s.dm_ready c%0d", tag, c), dm_ready, (c == L + 1) && !win_if);
            if (c <= L) begin
                chk16($sformatf("%s.mem_addr c%0d", tag, c), mem_addr, addr);
                chk1 ($sformatf("%s.mem_we c%0d", tag, c), mem_we, we);
                if (we) chk16($sformatf("%s.mem_wdata c%0d", tag, c), mem_wdata, wdata);
            end
            if (c == 2 && scramble) begin
                s_if_addr = if_addr; s_dm_addr = dm_addr; s_wdata = dm_wdata;
                s_we = dm_we; s_if_req = if_req; s_dm_req = dm_req;
                if_addr = if_addr ^ 16'h0030; dm_addr = dm_addr ^ 16'h0030;
                dm_wdata = ~dm_wdata; dm_we = ~dm_we; if_req = 1'b0; dm_req = 1'b0;
            end
            if (c == L + 1) begin
                if (scramble) begin
                    if_addr = s_if_addr; dm_addr = s_dm_addr; dm_wdata = s_wdata;
                    dm_we = s_we; if_req = s_if_req; dm_req = s_dm_req;
                end
                if (!we) begin
                    if (win_if) exp_if_rd = exp_rd;
                    else        exp_dm_rd = exp_rd;
                end
                chk16($sformatf("%s.if_rdata", tag), if_rdata, exp_if_rd);
                chk16($sformatf("%s.dm_rdata", tag), dm_rdata, exp_dm_rd);
            end
        end
    endtask

    // Step into the IDLE cycle that follows DONE.
    task automatic idle_step(input string tag);
        @(negedge clk);
        chk1($sformatf("%s.idle_en", tag), mem_en, 1'b0);
        chk1($sformatf("%s.idle_ifr", tag), if_ready, 1'b0);
        chk1($sformatf("%s.idle_dmr", tag), dm_ready, 1'b0);
    endtask

    typedef struct {
        bit          if_req;
        bit          dm_req;
        bit          dm_we;
        logic [15:0] if_addr;
        logic [15:0] dm_addr;
        logic [15:0] dm_wdata;
        bit          exp_if_win;
    } vec_t;

    vec_t vecs [9];

    // Random-phase requester and model state.
    bit          r_if, r_dm, r_we;
    logic [15:0] a_if, a_dm, r_wd;
    bit          m_busy, m_win_if, m_we, last_dm, exp_en, exp_done, idle_now;
    int          m_start;
    logic [15:0] m_addr, m_wd, m_rd;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

        // Single accesses from IDLE; arbitration history starts at fetch.
        vecs[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1};
        vecs[1] = '{0, 1, 0, 16'h0000, 16'h0011, 16'h0000, 0};
        vecs[2] = '{1, 1, 0, 16'h0020, 16'h0011, 16'h0000, 1};
        vecs[3] = '{1, 1, 1, 16'h0021, 16'h0012, 16'hBEEF, 0};
        vecs[4] = '{0, 1, 1, 16'h0000, 16'h0013, 16'hC0DE, 0};
        vecs[5] = '{1, 1, 0, 16'h0022, 16'h0012, 16'h0000, 1};
        vecs[6] = '{0, 1, 0, 16'h0000, 16'h0012, 16'h0000, 0};
        vecs[7] = '{1, 0, 0, 16'h0013, 16'h0000, 16'h0000, 1};
        vecs[8] = '{1, 1, 1, 16'h0023, 16'h0014, 16'h1111, 0};

        // Fetch only, 0x0010 -> 0xA5A5; address moved to 0x0020 mid-access.
        do_reset();
        if_req = 1; if_addr = 16'h0010;
        do_access("fetch", 1, 16'h0010, 0, 16'h0, 1);
        chk16("fetch.if_rdata_a5", if_rdata, 16'hA5A5);
        if_req = 0;
        idle_step("fetch");

        // Both held after reset: DM, IF, DM, IF.
        do_reset();
        if_req = 1; dm_req = 1; if_addr = 16'h0030; dm_addr = 16'h0031;
        do_access("rr0", 0, 16'h0031, 0, 16'h0, 0);
        idle_step("rr0");
        do_access("rr1", 1, 16'h0030, 0, 16'h0, 0);
        idle_step("rr1");
        do_access("rr2", 0, 16'h0031, 0, 16'h0, 0);
        idle_step("rr2");
        do_access("rr3", 1, 16'h0030, 0, 16'h0, 0);
        if_req = 0; dm_req = 0;
        idle_step("rr3");

        // Data read, then a write that must not disturb dm_rdata, then read back.
        dm_req = 1; dm_we = 0; dm_addr = 16'h0007;
        do_access("wr_pre", 0, 16'h0007, 0, 16'h0, 0);
        dm_req = 0;
        idle_step("wr_pre");
        dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
        do_access("wr", 0, 16'h0200, 1, 16'h1234, 0);
        dm_req = 0;
        idle_step("wr");
        dm_req = 1; dm_we = 0;
        do_access("wr_back", 0, 16'h0200, 0, 16'h0, 0);
        chk16("wr_back.value", dm_rdata, 16'h1234);
        dm_req = 0;
        idle_step("wr_back");

        // Reset in the second BUSY cycle aborts; held request restarts.
        do_reset();
        if_req = 1; if_addr = 16'h0040;
        @(negedge clk);
        chk1("abort.en_c1", mem_en, 1'b1);
        @(negedge clk);
        chk1("abort.en_c2", mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("abort.en_now", mem_en, 1'b0);
        chk16("abort.addr_now", mem_addr, 16'h0);
        chk1 ("abort.ifr_now", if_ready, 1'b0);
        @(negedge clk);
        chk1("abort.ifr_held", if_ready, 1'b0);
        chk1("abort.en_held", mem_en, 1'b0);
        rst_n = 1'b1;
        do_access("restart", 1, 16'h0040, 0, 16'h0, 0);
        if_req = 0;
        idle_step("restart");

        // Table of single accesses.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if_req = vecs[i].if_req; dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
            if_addr = vecs[i].if_addr; dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            do_access($sformatf("vec%0d", i), vecs[i].exp_if_win,
                      vecs[i].exp_if_win ? vecs[i].if_addr : vecs[i].dm_addr,
                      !vecs[i].exp_if_win && vecs[i].dm_we, vecs[i].dm_wdata, 1);
            if_req = 0; dm_req = 0;
            idle_step($sformatf("vec%0d", i));
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        r_if = 0; r_dm = 0; r_we = 0; a_if = '0; a_dm = '0; r_wd = '0;
        m_busy = 0; m_win_if = 0; m_we = 0; last_dm = 0; m_start = 0;
        m_addr = '0; m_wd = '0; m_rd = '0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            exp_en   = m_busy && (k >= m_start + 1) && (k <= m_start + L);
            exp_done = m_busy && (k == m_start + L + 1);
            idle_now = !m_busy;
            if (exp_done && !m_we) begin
                if (m_win_if) exp_if_rd = m_rd;
                else          exp_dm_rd = m_rd;
            end
            chk1("rnd.mem_en", mem_en, exp_en);
            chk1("rnd.if_ready", if_ready, exp_done && m_win_if);
            chk1("rnd.dm_ready", dm_ready, exp_done && !m_win_if);
            if (exp_en) begin
                chk16("rnd.mem_addr", mem_addr, m_addr);
                chk1 ("rnd.mem_we", mem_we, m_we);
                if (m_we) chk16("rnd.mem_wdata", mem_wdata, m_wd);
            end
            chk16("rnd.if_rdata", if_rdata, exp_if_rd);
            chk16("rnd.dm_rdata", dm_rdata, exp_dm_rd);
            if (exp_done) begin
                if (m_win_if) r_if = 0;
                else          r_dm = 0;
                m_busy = 0;
            end
            if (!r_if && $urandom_range(0, 2) == 0) begin
                r_if = 1; a_if = 16'($urandom) & 16'hFF1F;
            end
            if (!r_dm && $urandom_range(0, 2) == 0) begin
                r_dm = 1; a_dm = 16'($urandom) & 16'hFF1F;
                r_we = 1'($urandom_range(0, 1)); r_wd = 16'($urandom);
            end
            if_req = r_if; if_addr = a_if;
            dm_req = r_dm; dm_addr = a_dm; dm_we = r_we; dm_wdata = r_wd;
            if (idle_now && (r_if || r_dm)) begin
                m_win_if = r_if && (!r_dm || last_dm);
                last_dm  = !m_win_if;
                m_addr   = m_win_if ? a_if : a_dm;
                m_we     = !m_win_if && r_we;
                m_wd     = r_wd;
                m_rd     = ref_mem[m_addr[7:0]];
                if (m_we) ref_mem[m_addr[7:0]] = r_wd;
                m_busy   = 1;
                m_start  = k;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
